// File: rtl/irq_timer_pkg.sv
// Shared definitions for the IO-mapped interrupt controller / periodic timer:
// register map, CTRL bit positions and acknowledge FSM encoding.
package irq_timer_pkg;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_VBASE = 3'd2;
    localparam logic [2:0] REG_CTRL  = 3'd3;
    localparam logic [2:0] REG_RELL  = 3'd4;
    localparam logic [2:0] REG_RELH  = 3'd5;
    localparam logic [2:0] REG_CNTL  = 3'd6;
    localparam logic [2:0] REG_CNTH  = 3'd7;

    localparam int unsigned CTRL_TEN     = 0;
    localparam int unsigned CTRL_RESTART = 1;
    localparam int unsigned CTRL_GIE     = 7;

    localparam logic [2:0] SPURIOUS_IDX = 3'b111;

    typedef enum logic {
        ACK_IDLE,
        ACK_BUSY
    } ack_state_e;

endpackage

// File: rtl/irq_timer_tick.sv
// Prescaler plus 16-bit reloading down-counter; event_o pulses on the tick
// where the count passes 1, in the same clock the count reloads.
module irq_timer_tick #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        restart_i,
    input  logic [15:0] reload_i,
    output logic [15:0] count_o,
    output logic        event_o
);

    localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic [15:0]   count_q, count_d;
    logic          tick;

    always_comb begin
        tick    = en_i && (ps_q == PS_LAST);
        event_o = tick && !restart_i && (count_q == 16'd1);
        ps_d    = ps_q;
        count_d = count_q;
        if (restart_i) begin
            ps_d    = '0;
            count_d = reload_i;
        end else if (en_i) begin
            ps_d = tick ? '0 : ps_q + PW'(1);
            // A zero count (reload of 0) parks the timer instead of wrapping.
            if (tick) begin
                if (count_q == 16'd1) begin
                    count_d = reload_i;
                end else if (count_q != '0) begin
                    count_d = count_q - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q    <= '0;
            count_q <= '0;
        end else begin
            ps_q    <= ps_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/irq_timer.sv
// Z80 IM2 interrupt controller: merges timer and external level irqs into
// int_n and supplies the vector byte during the acknowledge cycle.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned NEXT     = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            we,
    input  logic [2:0]      addr,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    input  logic            m1_n,
    input  logic            iorq_n,
    input  logic [NEXT-1:0] irq_in,
    output logic            int_n,
    output logic            inta
);

    logic        cs_q;
    logic [NEXT:0] mask_q;
    logic [4:0]  vbase_q;
    logic        ten_q, gie_q;
    logic [15:0] reload_q;
    logic        tpend_q, tpend_d;
    logic [7:0]  hi_snap_q;
    ack_state_e  state_q;
    logic [7:0]  vec_q;
    logic        int_n_q;

    logic          ack_start, first, wr, wr_first, restart, tmr_event, found, ack_take;
    logic [15:0]   count;
    logic [NEXT:0] pending, masked;
    logic [2:0]    pend_idx;
    logic [7:0]    vec_now, reg_rdata;

    assign ack_start = ~m1_n & ~iorq_n;
    assign inta      = ~reset & ((state_q == ACK_BUSY) | ack_start);
    assign first     = cs & ~cs_q;
    assign wr        = cs & we & ~inta;
    assign wr_first  = wr & first;
    assign restart   = (wr_first && addr == REG_CTRL && din[CTRL_RESTART]) ||
                       (wr && addr == REG_CTRL && din[CTRL_TEN] && !ten_q);
    assign pending   = {irq_in, tpend_q};
    assign masked    = pending & mask_q;
    assign ack_take  = (state_q == ACK_IDLE) && ack_start && found && (pend_idx == 3'd0);

    irq_timer_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en_i      (ten_q),
        .restart_i (restart),
        .reload_i  (reload_q),
        .count_o   (count),
        .event_o   (tmr_event)
    );

    always_comb begin
        found    = 1'b0;
        pend_idx = SPURIOUS_IDX;
        for (int unsigned i = 0; i <= NEXT; i++) begin
            if (masked[i] && !found) begin
                found    = 1'b1;
                pend_idx = 3'(i);
            end
        end
        vec_now = found ? {vbase_q, pend_idx[1:0], 1'b0} : {vbase_q, SPURIOUS_IDX};
    end

    always_comb begin
        reg_rdata = '0;
        unique case (addr)
            REG_PEND:  reg_rdata = 8'(pending);
            REG_MASK:  reg_rdata = 8'(mask_q);
            REG_VBASE: reg_rdata = {vbase_q, 3'b000};
            REG_CTRL:  reg_rdata = {gie_q, 6'b0, ten_q};
            REG_RELL:  reg_rdata = reload_q[7:0];
            REG_RELH:  reg_rdata = reload_q[15:8];
            REG_CNTL:  reg_rdata = count[7:0];
            REG_CNTH:  reg_rdata = hi_snap_q;
        endcase
    end

    // The latched vector only exists from the second acknowledge clock on.
    assign dout = inta ? ((state_q == ACK_BUSY) ? vec_q : vec_now) :
                  cs   ? reg_rdata : 8'h00;

    // Timer set is applied last so it beats both W1C and acknowledge clears.
    always_comb begin
        tpend_d = tpend_q;
        if (wr_first && addr == REG_PEND && din[0]) tpend_d = 1'b0;
        if (ack_take)                               tpend_d = 1'b0;
        if (tmr_event)                              tpend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q      <= 1'b0;
            mask_q    <= '0;
            vbase_q   <= '0;
            ten_q     <= 1'b0;
            gie_q     <= 1'b0;
            reload_q  <= '0;
            tpend_q   <= 1'b0;
            hi_snap_q <= '0;
        end else begin
            cs_q    <= cs;
            tpend_q <= tpend_d;
            if (first && !we && addr == REG_CNTL) hi_snap_q <= count[15:8];
            if (wr) begin
                case (addr)
                    REG_MASK:  mask_q <= din[NEXT:0];
                    REG_VBASE: vbase_q <= din[7:3];
                    REG_CTRL: begin
                        ten_q <= din[CTRL_TEN];
                        gie_q <= din[CTRL_GIE];
                    end
                    REG_RELL:  reload_q[7:0]  <= din;
                    REG_RELH:  reload_q[15:8] <= din;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACK_IDLE;
            vec_q   <= '0;
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= ~(gie_q & |masked);
            unique case (state_q)
                ACK_IDLE: if (ack_start) begin
                    state_q <= ACK_BUSY;
                    vec_q   <= vec_now;
                end
                ACK_BUSY: if (m1_n) state_q <= ACK_IDLE;
            endcase
        end
    end

    assign int_n = int_n_q;

endmodule
